// File: rtl/envelope_follower.sv
// Envelope follower: rectifies a signed audio stream to an 8-bit level with attack/hold/release
// ballistics, a hysteretic gate and an optional full-scale flag (ENVELOPE_FOLLOWER_CLIP_EN).
module envelope_follower #(
    parameter int BITDEPTH = 14,
    parameter int HOLD_LEN = 16
) (
    input  logic                       sample_clock,
    input  logic                       rst,
    input  logic signed [BITDEPTH-1:0] in,
    input  logic [7:0]                 attack_rate,
    input  logic [7:0]                 release_rate,
    input  logic [7:0]                 threshold,
    output logic [7:0]                 level,
    output logic                       gate,
    output logic                       clip
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic signed [BITDEPTH-1:0] MAX_POS = {1'b0, {(BITDEPTH-1){1'b1}}};
    localparam logic signed [BITDEPTH-1:0] MIN_NEG = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_LEN);

    state_t        state;
    state_t        state_next;
    logic [15:0]   acc;
    logic [15:0]   acc_next;
    logic [7:0]    hold_cnt;
    logic [7:0]    hold_next;
    logic [7:0]    mag8;
    logic [BITDEPTH-1:0] abs_in;
    logic [15:0]   target;
    logic [16:0]   rise_sum;
    logic [16:0]   fall_diff;
    logic [15:0]   attack_val;
    logic [15:0]   release_val;

    // The most negative code has no positive twin, so it saturates to full scale.
    always_comb begin
        if (in == MIN_NEG) begin
            abs_in = $unsigned(MAX_POS);
        end else if (in[BITDEPTH-1]) begin
            abs_in = $unsigned(-in);
        end else begin
            abs_in = $unsigned(in);
        end
    end

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            mag8 <= 8'd0;
        end else begin
            mag8 <= 8'(abs_in >> (BITDEPTH - 9));
        end
    end

`ifdef ENVELOPE_FOLLOWER_CLIP_EN
    logic clip_q;

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= (in == MAX_POS) || (in == MIN_NEG);
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

    assign target = {mag8, 8'h00};
    assign level  = acc[15:8];

    // One spare bit keeps the step from wrapping past either end before clamping.
    assign rise_sum  = {1'b0, acc} + {5'b0, attack_rate, 4'b0};
    assign fall_diff = {1'b0, acc} - {5'b0, release_rate, 4'b0};

    always_comb begin
        attack_val = rise_sum[15:0];
        if ((attack_rate == 8'd0) || (rise_sum >= {1'b0, target})) begin
            attack_val = target;
        end
    end

    always_comb begin
        release_val = fall_diff[15:0];
        if ((release_rate == 8'd0) || fall_diff[16] || (fall_diff[15:0] <= target)) begin
            release_val = target;
        end
    end

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= 16'd0;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            hold_cnt <= hold_next;
        end
    end

    // A rising target always wins; otherwise each state runs its own ballistics.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        hold_next  = hold_cnt;
        if (target > acc) begin
            acc_next = attack_val;
            if (attack_val == target) begin
                state_next = HOLD;
                hold_next  = HOLD_RELOAD;
            end else begin
                state_next = ATTACK;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                ATTACK: begin
                    state_next = HOLD;
                    hold_next  = HOLD_RELOAD;
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        if (target < acc) begin
                            state_next = RELEASE;
                        end
                    end else if (mag8 == level) begin
                        hold_next = HOLD_RELOAD;
                    end else begin
                        hold_next = hold_cnt - 8'd1;
                    end
                end
                RELEASE: begin
                    acc_next = release_val;
                    if (release_val == target) begin
                        if (release_val == 16'd0) begin
                            state_next = IDLE;
                        end else begin
                            state_next = HOLD;
                            hold_next  = HOLD_RELOAD;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Between threshold/2 and threshold the gate keeps its previous value.
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            gate <= 1'b0;
        end else if ((threshold == 8'd0) && (level == 8'd0)) begin
            gate <= 1'b0;
        end else if (level > threshold) begin
            gate <= 1'b1;
        end else if (level < (threshold >> 1)) begin
            gate <= 1'b0;
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Directed self-checking bench for envelope_follower (default parameters, clip
// expectations follow ENVELOPE_FOLLOWER_CLIP_EN).
module tb_envelope_follower;

    logic              sample_clock;
    logic              rst;
    logic signed [13:0] in;
    logic [7:0]        attack_rate;
    logic [7:0]        release_rate;
    logic [7:0]        threshold;
    logic [7:0]        level;
    logic              gate;
    logic              clip;

    int checks;
    int fails;

`ifdef ENVELOPE_FOLLOWER_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    envelope_follower #(.BITDEPTH(14), .HOLD_LEN(16)) dut (
        .sample_clock (sample_clock),
        .rst          (rst),
        .in           (in),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .threshold    (threshold),
        .level        (level),
        .gate         (gate),
        .clip         (clip)
    );

    initial sample_clock = 1'b0;
    always #5 sample_clock = ~sample_clock;

    task automatic tick;
        @(posedge sample_clock);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in  = 14'(0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        in = 14'(8191);
        attack_rate = 8'd0;
        tick;
        checks++;
        if (level !== 8'd0) begin
            fails++; $display("[TB] FAIL reset_level: got %0d expected 0", level);
        end
        checks++;
        if (gate !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_gate: got %0d expected 0", gate);
        end
        checks++;
        if (clip !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_clip: got %0d expected 0", clip);
        end
        checks++;
        if (dut.mag8 !== 8'd0) begin
            fails++; $display("[TB] FAIL reset_mag8: got %0d expected 0", dut.mag8);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            fails++; $display("[TB] FAIL reset_state: got %0d expected 0", dut.state);
        end
        checks++;
        if (dut.hold_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL reset_hold_cnt: got %0d expected 0", dut.hold_cnt);
        end
    endtask

    task automatic test_instant_attack;
        do_reset;
        attack_rate = 8'd0;
        in = 14'(4096);
        tick;
        checks++;
        if (dut.mag8 !== 8'd128) begin
            fails++; $display("[TB] FAIL instant_mag8: got %0d expected 128", dut.mag8);
        end
        checks++;
        if (level !== 8'd0) begin
            fails++; $display("[TB] FAIL instant_level_early: got %0d expected 0", level);
        end
        tick;
        checks++;
        if (level !== 8'd128) begin
            fails++; $display("[TB] FAIL instant_level: got %0d expected 128", level);
        end
        tick;
        checks++;
        if (dut.state !== 2'd2) begin
            fails++; $display("[TB] FAIL instant_state_hold: got %0d expected 2", dut.state);
        end
        checks++;
        if (dut.hold_cnt !== 8'd16) begin
            fails++; $display("[TB] FAIL instant_hold_cnt: got %0d expected 16", dut.hold_cnt);
        end
    endtask

    task automatic test_slow_attack;
        int exp_lvl;
        do_reset;
        attack_rate = 8'd1;
        in = 14'(8191);
        tick;
        checks++;
        if (dut.mag8 !== 8'd255) begin
            fails++; $display("[TB] FAIL slow_mag8: got %0d expected 255", dut.mag8);
        end
        for (int k = 1; k <= 4100; k++) begin
            tick;
            exp_lvl = (k / 16 > 255) ? 255 : k / 16;
            checks++;
            if (level !== 8'(exp_lvl)) begin
                fails++; $display("[TB] FAIL slow_level k=%0d: got %0d expected %0d", k, level, exp_lvl);
            end
            if (k == 100) begin
                checks++;
                if (dut.state !== 2'd1) begin
                    fails++; $display("[TB] FAIL slow_state_attack: got %0d expected 1", dut.state);
                end
            end
        end
        checks++;
        if (dut.acc !== 16'hFF00) begin
            fails++; $display("[TB] FAIL slow_no_overshoot: got %0h expected ff00", dut.acc);
        end
        checks++;
        if (dut.state !== 2'd2) begin
            fails++; $display("[TB] FAIL slow_state_hold: got %0d expected 2", dut.state);
        end
    endtask

    // Runs straight after test_slow_attack, starting from level 255 in HOLD.
    task automatic test_release;
        int exp_acc;
        release_rate = 8'd255;
        in = 14'(0);
        for (int e = 1; e <= 40; e++) begin
            tick;
            exp_acc = (e <= 18) ? 65280 : 65280 - 4080 * (e - 18);
            if (exp_acc < 0) exp_acc = 0;
            checks++;
            if (level !== 8'(exp_acc / 256)) begin
                fails++; $display("[TB] FAIL release_level e=%0d: got %0d expected %0d", e, level, exp_acc / 256);
            end
            if (e == 20) begin
                checks++;
                if (dut.state !== 2'd3) begin
                    fails++; $display("[TB] FAIL release_state: got %0d expected 3", dut.state);
                end
            end
        end
        checks++;
        if (dut.state !== 2'd0) begin
            fails++; $display("[TB] FAIL release_state_idle: got %0d expected 0", dut.state);
        end
    endtask

    task automatic test_gate_hysteresis;
        do_reset;
        threshold = 8'd100;
        attack_rate = 8'd0;
        release_rate = 8'd0;
        in = 14'(3200);
        repeat (4) tick;
        checks++;
        if (level !== 8'd100 || gate !== 1'b0) begin
            fails++; $display("[TB] FAIL gate_at_100: got level %0d gate %0d expected 100 0", level, gate);
        end
        in = 14'(3840);
        tick;
        tick;
        checks++;
        if (level !== 8'd120 || gate !== 1'b0) begin
            fails++; $display("[TB] FAIL gate_latency: got level %0d gate %0d expected 120 0", level, gate);
        end
        tick;
        checks++;
        if (gate !== 1'b1) begin
            fails++; $display("[TB] FAIL gate_set_120: got %0d expected 1", gate);
        end
        in = 14'(2400);
        repeat (25) tick;
        checks++;
        if (level !== 8'd75 || gate !== 1'b1) begin
            fails++; $display("[TB] FAIL gate_hold_75: got level %0d gate %0d expected 75 1", level, gate);
        end
        in = 14'(1600);
        repeat (25) tick;
        checks++;
        if (level !== 8'd50 || gate !== 1'b1) begin
            fails++; $display("[TB] FAIL gate_hold_50: got level %0d gate %0d expected 50 1", level, gate);
        end
        in = 14'(1280);
        repeat (25) tick;
        checks++;
        if (level !== 8'd40 || gate !== 1'b0) begin
            fails++; $display("[TB] FAIL gate_clear_40: got level %0d gate %0d expected 40 0", level, gate);
        end
    endtask

    task automatic test_gate_zero_threshold;
        do_reset;
        threshold = 8'd0;
        attack_rate = 8'd0;
        release_rate = 8'd0;
        in = 14'(320);
        repeat (4) tick;
        checks++;
        if (level !== 8'd10 || gate !== 1'b1) begin
            fails++; $display("[TB] FAIL zero_thr_set: got level %0d gate %0d expected 10 1", level, gate);
        end
        in = 14'(0);
        repeat (25) tick;
        checks++;
        if (level !== 8'd0 || gate !== 1'b0) begin
            fails++; $display("[TB] FAIL zero_thr_clear: got level %0d gate %0d expected 0 0", level, gate);
        end
    endtask

    task automatic test_clip;
        do_reset;
        attack_rate = 8'd0;
        in = 14'(-8192);
        tick;
        checks++;
        if (dut.mag8 !== 8'd255) begin
            fails++; $display("[TB] FAIL clip_neg_mag8: got %0d expected 255", dut.mag8);
        end
        checks++;
        if (clip !== CLIP_ON) begin
            fails++; $display("[TB] FAIL clip_neg_pulse: got %0d expected %0d", clip, CLIP_ON);
        end
        in = 14'(0);
        tick;
        checks++;
        if (clip !== 1'b0 || level !== 8'd255) begin
            fails++; $display("[TB] FAIL clip_neg_end: got clip %0d level %0d expected 0 255", clip, level);
        end
        in = 14'(8191);
        tick;
        checks++;
        if (clip !== CLIP_ON) begin
            fails++; $display("[TB] FAIL clip_pos: got %0d expected %0d", clip, CLIP_ON);
        end
        in = 14'(8190);
        tick;
        checks++;
        if (clip !== 1'b0 || dut.mag8 !== 8'd255) begin
            fails++; $display("[TB] FAIL clip_near_pos: got clip %0d mag8 %0d expected 0 255", clip, dut.mag8);
        end
        in = 14'(-8191);
        tick;
        checks++;
        if (clip !== 1'b0 || dut.mag8 !== 8'd255) begin
            fails++; $display("[TB] FAIL clip_near_neg: got clip %0d mag8 %0d expected 0 255", clip, dut.mag8);
        end
    endtask

    task automatic test_reset_mid_attack;
        bit found;
        do_reset;
        threshold = 8'd30;
        attack_rate = 8'd1;
        in = 14'(8191);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick;
            if (level == 8'd60) found = 1'b1;
        end
        checks++;
        if (!found) begin
            fails++; $display("[TB] FAIL midreset_reach_60: got level %0d expected 60 within 3000 cycles", level);
        end
        checks++;
        if (gate !== 1'b1) begin
            fails++; $display("[TB] FAIL midreset_gate_before: got %0d expected 1", gate);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (level !== 8'd0 || gate !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_async: got level %0d gate %0d expected 0 0", level, gate);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            fails++; $display("[TB] FAIL midreset_state: got %0d expected 0", dut.state);
        end
        #2;
        rst = 1'b0;
        tick;
        checks++;
        if (dut.acc !== 16'd0) begin
            fails++; $display("[TB] FAIL midreset_no_partial: got acc %0d expected 0", dut.acc);
        end
        tick;
        checks++;
        if (dut.acc !== 16'd16) begin
            fails++; $display("[TB] FAIL midreset_first_step: got acc %0d expected 16", dut.acc);
        end
        repeat (15) tick;
        checks++;
        if (dut.acc !== 16'd256 || level !== 8'd1) begin
            fails++; $display("[TB] FAIL midreset_resume: got acc %0d level %0d expected 256 1", dut.acc, level);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        in = 14'(0);
        attack_rate = 8'd0;
        release_rate = 8'd0;
        threshold = 8'd255;
        $display("[TB] starting envelope_follower bench");
        test_reset;
        test_instant_attack;
        test_slow_attack;
        test_release;
        test_gate_hysteresis;
        test_gate_zero_threshold;
        test_clip;
        test_reset_mid_attack;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/envelope_follower.md
ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

Interface
REQ-001 SHALL have parameter BITDEPTH, default 14: width of signed two's-complement audio input.
REQ-002 SHALL have parameter HOLD_LEN, default 16, legal 1..255: peak-hold time in samples.
REQ-003 SHALL have port sample_clock  input  1  single clock; one audio sample per rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in  input  BITDEPTH  signed audio sample.
REQ-006 SHALL have port attack_rate  input  8  rise step; 0 = instant.
REQ-007 SHALL have port release_rate  input  8  fall step; 0 = instant.
REQ-008 SHALL have port threshold  input  8  gate-on level.
REQ-009 SHALL have port level  output  8  tracked amplitude, 0..255, volume-compatible.
REQ-010 SHALL have port gate  output  1  threshold detector, drives an envelope gate input directly.
REQ-011 SHALL have port clip  output  1  full-scale input flag.

Function
REQ-012 SHALL register mag8 = bits [BITDEPTH-2 -: 8] of |in|, with -2^(BITDEPTH-1) saturated to 2^(BITDEPTH-1)-1. BITDEPTH=14: in=4096 -> 128; 8191 or -8192 -> 255.
REQ-013 SHALL keep a 16-bit accumulator acc, with level = acc[15:8] and target T = {mag8, 8'h00}.
REQ-014 SHALL use a state machine with states IDLE, ATTACK, HOLD, RELEASE.
REQ-015 SHALL, in every state, enter ATTACK when T > acc; this takes priority over all other transitions.
REQ-016 SHALL, in ATTACK, step acc by attack_rate*16 per sample, clamped at T with no overshoot; attack_rate=0 loads T in one step.
REQ-017 SHALL, on acc reaching T in ATTACK, enter HOLD and load hold_cnt with HOLD_LEN.
REQ-018 SHALL, in HOLD, decrement hold_cnt per sample and reload it to HOLD_LEN when mag8 == level; at hold_cnt == 0 with T < acc, enter RELEASE; at hold_cnt == 0 otherwise, stay in HOLD.
REQ-019 SHALL, in RELEASE, decrement acc by release_rate*16 per sample, clamped at T with no undershoot; release_rate=0 loads T in one step.
REQ-020 SHALL, on acc reaching T in RELEASE, enter IDLE if acc == 0, else enter HOLD with hold_cnt reloaded.
REQ-021 SHALL keep acc unchanged in IDLE while T == 0.
REQ-022 SHALL have latency as follows: in sampled at edge N affects acc at edge N+1, level is combinational from acc, and gate updates at edge N+2.
REQ-023 SHALL register gate with hysteresis: set when level > threshold; clear when level < threshold>>1; otherwise hold.
REQ-024 SHALL hold gate at 0 when threshold == 0 and level == 0.
REQ-025 SHALL compute acc in 17-bit arithmetic so that no step wraps around 0 or 65535.

Reset
REQ-026 SHALL, while rst is high, force acc, mag8 register, hold_cnt, gate and clip to 0 and state to IDLE, asynchronously, independent of sample_clock.
REQ-027 SHALL, on rst asserted mid-ATTACK or mid-RELEASE, drop level to 0 immediately, with no partial step after release of rst.
REQ-028 SHALL evaluate normally from the first sample_clock edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro ENVELOPE_FOLLOWER_CLIP_EN defined, register clip = 1 for each sample where in equals +2^(BITDEPTH-1)-1 or -2^(BITDEPTH-1), with the same latency as mag8.
REQ-030 SHALL, without ENVELOPE_FOLLOWER_CLIP_EN, tie clip to constant 0 and retain the port; all other behaviour is identical.

Verification
REQ-031 SHALL cover: attack_rate=0, in=4096 held -> level=128 two edges after application; state HOLD.
REQ-032 SHALL cover: attack_rate=1, in=8191 from reset -> level +1 every 16 samples; level=255 after 4080 samples; no overshoot.
REQ-033 SHALL cover: level=255 then in=0, release_rate=255 -> level holds for HOLD_LEN=16 samples, then reaches 0 within 16 further samples; state IDLE.
REQ-034 SHALL cover: threshold=100, with level ramped 0->120->75->40 -> gate sets when level crosses above 100, stays 1 at 75, clears below 50.
REQ-035 SHALL cover: in=-8192 for one sample -> mag8=255; clip pulses 1 cycle with ENVELOPE_FOLLOWER_CLIP_EN, stays 0 without it.
REQ-036 SHALL cover: rst asserted between edges mid-ATTACK at level=60 -> level=0 and gate=0 before the next edge; normal attack resumes after deassertion.
